// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: N valid/ready/last input lanes feeding one
// registered valid/ready/last output lane.
interface stream_mux_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic                      out_last;
  logic                      out_ready;

  // slave is the multiplexer's own view; master is the surrounding fabric
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_mux.sv
// N-channel packet stream multiplexer: per-packet grant by external select or
// round-robin, lock held until the last beat is accepted, registered output.
module stream_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_if.slave      bus,
  output logic [SEL_W-1:0] cur_chan,
  output logic             busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [SEL_W-1:0]    rr_q, rr_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic [CHANNELS-1:0] ready_vec;
  logic                slot_free;
  logic                cur_valid;
  logic [WIDTH-1:0]    cur_data;
  logic                cur_last;
  logic                sel_hit;
  logic                rr_found;
  logic [SEL_W-1:0]    rr_idx;
  logic                accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      rr_q        <= SEL_W'(CHANNELS - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    ready_vec   = '0;
    cur_valid   = 1'b0;
    cur_data    = '0;
    cur_last    = 1'b0;
    sel_hit     = 1'b0;
    rr_found    = 1'b0;
    rr_idx      = '0;
    accept      = 1'b0;
    slot_free   = !out_valid_q || bus.out_ready;

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(cur_q) == k) begin
        cur_valid = bus.in_valid[k];
        cur_data  = bus.in_data[k*WIDTH +: WIDTH];
        cur_last  = bus.in_last[k];
      end
      // an out-of-range select never matches any channel
      if (32'(sel) == k && bus.in_valid[k]) sel_hit = 1'b1;
    end

    // round-robin: channels above rr_q first, then wrap to those at or below it
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!rr_found && bus.in_valid[k] && k > 32'(rr_q)) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'(k);
      end
    end
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!rr_found && bus.in_valid[k] && k <= 32'(rr_q)) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'(k);
      end
    end

    if (bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mode ? rr_found : sel_hit) begin
          cur_d   = mode ? rr_idx : sel;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          if (32'(cur_q) == k) ready_vec[k] = slot_free;
        end
        accept = cur_valid && slot_free;
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = cur_data;
          out_last_d  = cur_last;
          if (cur_last) begin
            rr_d    = cur_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign cur_chan      = cur_q;
  assign busy          = (state_q == LOCKED);

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel, W-bit packet stream multiplexer with valid/ready handshakes on every channel and a registered output stage. It selects one input channel per packet, either from an externally driven select or by round-robin arbitration, and holds that channel until the packet's last beat has been accepted. It sits in front of any single-consumer datapath that the team previously fed from fixed 2:1 combinational muxes.

## Interface
- WIDTH, 8, data width per channel in bits (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, 2, select/channel-index width; CHANNELS ≤ 2**SEL_W
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = external select, 1 = round-robin
- sel  in  SEL_W  channel index used when mode=0
- in_valid  in  CHANNELS  per-channel beat valid
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_last  in  CHANNELS  per-channel end-of-packet flag
- in_ready  out  CHANNELS  per-channel accept; at most one bit high
- out_valid  out  1  output beat valid
- out_data  out  WIDTH  output beat data
- out_last  out  1  output end-of-packet flag
- out_ready  in  1  downstream accept
- cur_chan  out  SEL_W  channel currently or last granted
- busy  out  1  high while in LOCKED

## Operation
- FSM states: IDLE, LOCKED.
- IDLE, mode=0: grant when sel < CHANNELS and in_valid[sel]=1. If sel ≥ CHANNELS, no grant ever.
- IDLE, mode=1: grant the first k with in_valid[k]=1, searching from rr_ptr+1 upward and wrapping modulo CHANNELS.
- On grant: cur_chan ← k, busy ← 1, go to LOCKED. mode and sel are sampled only on the grant cycle; changes during LOCKED are ignored.
- LOCKED: in_ready[cur_chan] = !out_valid || out_ready. All other in_ready bits are 0. All in_ready bits are 0 in IDLE.
- Accept occurs when in_valid[cur_chan] && in_ready[cur_chan]. On accept, out_data, out_last ← in_data slice, in_last[cur_chan], and out_valid ← 1.
- Output register: cleared (out_valid ← 0) when out_ready=1 and no accept occurs in the same cycle. Simultaneous drain and accept replaces the held beat with no bubble.
- Accept with in_last=1: rr_ptr ← cur_chan, busy ← 0, go to IDLE. cur_chan keeps its value.
- The held output beat may still be pending when a new grant occurs. The new channel's in_ready stays gated by the register.
- Packets are never interleaved. Beats on ungranted channels are not consumed.
- Reset values: out_valid=0, out_data=0, out_last=0, in_ready=0, cur_chan=0, busy=0, state=IDLE, rr_ptr=CHANNELS-1 (channel 0 has first priority).
- Reset asserted mid-packet discards the held beat and the lock immediately. There is no partial-packet recovery.

## Timing
- Cycle n: IDLE with a qualifying in_valid. Edge n→n+1: grant.
- Cycle n+1: in_ready[k]=1. Edge n+1→n+2: first accept.
- Cycle n+2: out_valid=1. Latency from accept to out_valid is 1 cycle; grant adds 1 cycle.
- Within a packet with out_ready held at 1, throughput is 1 beat per cycle.
- Between packets there is exactly 1 IDLE cycle (one bubble).
- While out_ready=0 and out_valid=1, out_data and out_last are held stable and in_ready is 0.
- Single-beat packet (in_last on the first beat): returns to IDLE one edge after the grant edge.
- Outputs are all registered, except in_ready, which is combinational from state, out_valid and out_ready.

## Test plan
- Reset mid-packet: mode=1, ch1 sends 3 beats, reset asserted after beat 1 → all outputs go to their reset values asynchronously and cur_chan=0; after release, ch0 wins first.
- Fixed select: mode=0, sel=2, ch2 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) with out_ready=1, ch0 and ch1 valid throughout → out_data is 0xA1, 0xA2, 0xA3 on consecutive cycles, out_last only on 0xA3, in_ready[0] and in_ready[1] stay 0.
- Round-robin fairness: mode=1, all four channels continuously valid with 1-beat packets of data 0x10+k → output sequence 0x10, 0x11, 0x12, 0x13, 0x10 with one bubble between beats.
- Backpressure: mid-packet, out_ready=0 for 3 cycles → out_data is unchanged, in_ready[cur_chan]=0; after release, the remaining beats arrive in order with none lost or duplicated.
- Lock holds: mode=0, sel changed 1→3 during a ch1 packet → ch1 packet completes, then ch3 is granted.
- Invalid select: CHANNELS=3, SEL_W=2, mode=0, sel=3 with all channels valid → busy stays 0, out_valid stays 0.
